// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path widths, enable encodings and the fetch-queue entry layout.
// Pure definitions, no logic.
package inst_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [InstAddrBus-1:0] next_pc(input logic [InstAddrBus-1:0] pc);
        return pc + InstAddrBus'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch queue with synchronous flush; flush beats push and pop.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push accepted only when not full (or popping); pop on empty is ignored.
module fetch_fifo #(
    parameter int Depth = 2,
    parameter int Width = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic                       head_vld_o,
    output logic [Width-1:0]           head_dat_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_i && !flush_i && (count_q != '0);
        push_ok  = push_i && !flush_i && ((count_q != CntW'(Depth)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointer overflow is the modulo wrap.
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC into a combinational ROM, buffered for decode.
// Latency: one cycle from ROM fetch to id_valid_o; redirect target fetched the cycle after branch.
// Backpressure: fetch stalls when the queue is full and decode is not popping; FifoDepth is 2 or 4.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] ResetPc   = 32'h0000_0000,
    parameter int                     FifoDepth = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_data_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o
);

    localparam int CntW = $clog2(FifoDepth) + 1;

    logic                   run_q, run_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [CntW-1:0]        count;
    logic                   head_vld;
    fetch_entry_t           head_entry;
    fetch_entry_t           push_entry;
    logic                   fetch;
    logic                   pop;
    logic                   unused_tgt_lsb;

    assign unused_tgt_lsb = ^branch_target_i[1:0];
    assign pop            = head_vld && id_ready_i;

    always_comb begin
        fetch      = run_q && !branch_flag_i && ((count < CntW'(FifoDepth)) || pop);
        run_d      = 1'b1;
        pc_d       = pc_q;
        push_entry = '{pc: pc_q, inst: rom_data_i};
        if (branch_flag_i) begin
            pc_d = {branch_target_i[InstAddrBus-1:2], 2'b00};
        end else if (fetch) begin
            pc_d = next_pc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
            pc_q  <= ResetPc;
        end else begin
            run_q <= run_d;
            pc_q  <= pc_d;
        end
    end

    fetch_fifo #(
        .Depth (FifoDepth),
        .Width ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .flush_i    (branch_flag_i),
        .push_i     (fetch),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_vld_o (head_vld),
        .head_dat_o (head_entry),
        .count_o    (count)
    );

    assign rom_ce_o   = fetch ? ChipEnable : ChipDisable;
    assign rom_addr_o = fetch ? pc_q : '0;
    assign id_valid_o = head_vld;
    assign id_pc_o    = head_entry.pc;
    assign id_inst_o  = head_entry.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed phases push expected PCs, monitors check decode handshakes.
// A second instance with ResetPc near the top of memory covers address wrap.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        branch, branch2;
    logic [31:0] target, target2;
    logic        ready, ready2;

    logic        rom_ce, rom_ce2;
    logic [31:0] rom_addr, rom_addr2, rom_data, rom_data2;
    logic        id_valid, id_valid2;
    logic [31:0] id_pc, id_pc2, id_inst, id_inst2;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign rom_data  = rom_word(rom_addr);
    assign rom_data2 = rom_word(rom_addr2);

    inst_fetch #(.ResetPc(32'h0000_0000), .FifoDepth(2)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .branch_flag_i(branch), .branch_target_i(target),
        .id_valid_o(id_valid), .id_ready_i(ready),
        .id_pc_o(id_pc), .id_inst_o(id_inst)
    );

    inst_fetch #(.ResetPc(32'hFFFF_FFF8), .FifoDepth(2)) dut_wrap (
        .clk(clk), .rst(rst2),
        .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2), .rom_data_i(rom_data2),
        .branch_flag_i(branch2), .branch_target_i(target2),
        .id_valid_o(id_valid2), .id_ready_i(ready2),
        .id_pc_o(id_pc2), .id_inst_o(id_inst2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Decode-side monitors: every accepted instruction must match the next expected PC.
    always @(negedge clk) begin
        if (rst && id_valid && ready && !branch) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", id_pc, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pop_pc", id_pc, e);
                check("pop_inst", id_inst, rom_word(e));
            end
        end
    end

    always @(negedge clk) begin
        if (rst2 && id_valid2 && ready2 && !branch2) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_pop2", id_pc2, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp2_q.pop_front();
                check("wrap_pc", id_pc2, e);
                check("wrap_inst", id_inst2, rom_word(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        branch = 1'b0; branch2 = 1'b0;
        target = '0; target2 = '0;
        ready = 1'b1; ready2 = 1'b1;

        // Reset state and release timing, streaming with ready held high.
        repeat (2) step();
        mid();
        check("rst_ce", 32'(rom_ce), 32'd0);
        check("rst_addr", rom_addr, 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_inst", id_inst, 32'd0);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        step();
        rst = 1'b1;
        mid();
        check("ce_before_run", 32'(rom_ce), 32'd0);
        step();
        mid();
        check("first_ce", 32'(rom_ce), 32'd1);
        check("first_addr", rom_addr, 32'd0);
        check("first_valid", 32'(id_valid), 32'd0);
        repeat (7) step();
        ready = 1'b0;
        step();
        mid();
        check("stall_head_pc", id_pc, 32'h18);
        check("stall_ce", 32'(rom_ce), 32'd0);
        // Asynchronous reset with two entries held: outputs clear before any edge.
        rst = 1'b0;
        #1;
        check("async_valid", 32'(id_valid), 32'd0);
        check("async_pc", id_pc, 32'd0);
        check("async_inst", id_inst, 32'd0);
        check("async_ce", 32'(rom_ce), 32'd0);
        check("async_addr", rom_addr, 32'd0);
        check("flushed_by_reset", 32'(exp_q.size()), 32'd0);

        // Ready low from start: exactly two fetches, then hold.
        repeat (2) step();
        rst = 1'b1;
        step(); mid();
        check("bp_fetch0_ce", 32'(rom_ce), 32'd1);
        check("bp_fetch0_addr", rom_addr, 32'h0);
        step(); mid();
        check("bp_fetch1_ce", 32'(rom_ce), 32'd1);
        check("bp_fetch1_addr", rom_addr, 32'h4);
        step(); mid();
        check("bp_full_ce", 32'(rom_ce), 32'd0);
        check("bp_full_addr", rom_addr, 32'd0);
        step(); mid();
        check("bp_hold_ce", 32'(rom_ce), 32'd0);
        check("bp_head_pc", id_pc, 32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        step();
        ready = 1'b1;
        repeat (4) step();
        ready = 1'b0;

        // Redirect while full: queued 0x10/0x14 and PC 0x18 are discarded.
        step();
        branch = 1'b1; target = 32'h100; ready = 1'b1;
        mid();
        check("br_ce", 32'(rom_ce), 32'd0);
        check("br_addr", rom_addr, 32'd0);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        step();
        branch = 1'b0;
        mid();
        check("br_target_ce", 32'(rom_ce), 32'd1);
        check("br_target_addr", rom_addr, 32'h100);
        check("br_gap_valid", 32'(id_valid), 32'd0);
        repeat (4) step();
        ready = 1'b0;

        // Back-to-back redirects; the unaligned last target is word-aligned.
        step();
        branch = 1'b1; target = 32'h300;
        step();
        target = 32'h203;
        step();
        branch = 1'b0;
        mid();
        check("b2b_addr0", rom_addr, 32'h200);
        check("b2b_ce0", 32'(rom_ce), 32'd1);
        step(); mid();
        check("b2b_addr1", rom_addr, 32'h204);
        step(); mid();
        check("b2b_full_ce", 32'(rom_ce), 32'd0);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
        step();
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;

        // PC wrap across the top of the address space on the second instance.
        exp2_q.push_back(32'hFFFF_FFF8); exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000); exp2_q.push_back(32'h0000_0004);
        step();
        rst2 = 1'b1;
        step(); mid();
        check("wrap_first_addr", rom_addr2, 32'hFFFF_FFF8);
        repeat (5) step();
        ready2 = 1'b0;

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_scoreboard_drained", 32'(exp2_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
